key_unlock_seq: RTL and testbench
=================================

// Module: key_unlock_seq
// PURPOSE
//  Sequencer for one locked netlist paired with its golden copy.
//  Loads the locking key serially and drives it onto lockingkeyinput.
//  Sweeps all 2^IN_W primary-input patterns through the pair and counts
//  patterns whose per-output equality flags (Q) are not all ones.
//  Reports pass/fail. On fail it can zeroise the key, so a wrong key never stays applied.
// PARAMETERS
//  KEY_W          6  locking-key width; width of key_q
//  IN_W           5  primary-input width; the sweep covers 2^IN_W patterns
//  OUT_W          2  width of the eq input (one equality flag per output)
//  CLEAR_ON_FAIL  1  1: key register cleared to 0 in DONE when pass=0
// PORTS
//  C             in   1          clock; all state changes on posedge
//  R             in   1          async reset, active-low
//  start         in   1          1-cycle request; accepted only in IDLE
//  abort         in   1          synchronous abort, any state
//  key_sdi       in   1          serial key bit, MSB first
//  key_sdi_vld   in   1          key_sdi qualifier
//  eq            in   OUT_W      equality flags from the compare wrapper, combinational from pi/key_q
//  pi            out  IN_W       registered pattern to both circuits
//  key_q         out  KEY_W      key register; drives lockingkeyinput
//  key_ok        out  1          1 while idle with a passed key
//  busy          out  1          1 in LOAD/SWEEP/DONE
//  done          out  1          1-cycle pulse in DONE
//  pass          out  1          result; valid from DONE until next accepted start
//  mismatch_cnt  out  IN_W+1     failing-pattern count (max 2^IN_W, no saturation)
// BEHAVIOUR
//  Reset (R=0, async): state=IDLE; pi, key_q, mismatch_cnt = 0; busy, done, pass, key_ok = 0.
//  States: IDLE -> LOAD -> SWEEP -> DONE -> IDLE.
//  IDLE:
//   - start=1 -> LOAD next cycle.
//   - On that edge: bit_cnt, mismatch_cnt, pass, key_ok cleared; key_q cleared.
//  LOAD:
//   - Each key_sdi_vld=1 cycle: key_q <= {key_q[KEY_W-2:0], key_sdi}; bit_cnt++.
//   - key_sdi_vld=0 stalls LOAD indefinitely; no timeout.
//   - Beat with bit_cnt==KEY_W-1 -> SWEEP next cycle, with pi=0.
//  SWEEP:
//   - One pattern per cycle; pi increments by 1 each cycle.
//   - eq is sampled in the same cycle the pattern is on pi.
//   - eq != all ones -> mismatch_cnt++.
//   - After the cycle with pi = 2^IN_W-1 -> DONE.
//   - pi then wraps to 0 and stays 0 outside SWEEP.
//   - SWEEP always lasts exactly 2^IN_W cycles; no early exit on mismatch.
//  DONE (one cycle):
//   - done=1; pass = (mismatch_cnt==0), registered into DONE.
//   - If pass=0 and CLEAR_ON_FAIL: key_q <= 0.
//   - Next state is IDLE; key_ok <= pass.
//  Latency: start seen at cycle 0 with key_sdi_vld held high -> DONE at cycle KEY_W+2^IN_W+1 (39 for defaults).
//  Boundaries:
//   - start outside IDLE: ignored.
//   - key_sdi_vld outside LOAD: ignored.
//   - abort has priority over start and over all transitions. Next state IDLE; key_q, mismatch_cnt, pass, key_ok <= 0; done not pulsed.
//   - start and abort in the same IDLE cycle: abort wins, stays IDLE.
//   - Async reset mid-operation: all state and outputs return to reset values immediately.
// STRUCTURE
//  key_unlock_pkg:
//   - state encoding, 2-bit localparams ST_IDLE=0, ST_LOAD=1, ST_SWEEP=2, ST_DONE=3;
//   - default KEY_W/IN_W/OUT_W constants.
//  One sub-module, key_shift_reg: KEY_W serial-in/parallel-out register with shift-enable and sync clear, reset on R.
//  FSM, pattern counter and mismatch counter stay in key_unlock_seq.
// TESTING
//  Bench instantiates key_unlock_seq with the locked circuit, its golden copy and the eq/Q compare wrapper.
//  1. Correct key 6'b001010 shifted MSB first, key_sdi_vld always 1 -> done at cycle 39; pass=1; mismatch_cnt=0; key_ok=1; key_q=6'b001010.
//  2. Alternate correct key 6'b111010 (k4==k5) -> pass=1; mismatch_cnt=0.
//  3. Wrong key 6'b001110 (k2 flipped, N22 inverted) -> mismatch_cnt=32; pass=0; key_q=0 after DONE; key_ok=0.
//  4. Key beats with key_sdi_vld toggling 1,0,1,0 -> same result as test 1. done arrives 5 cycles later, one per stall cycle.
//  5. abort in SWEEP at pi=10 -> IDLE next cycle; no done pulse; key_q=0. A new start then completes normally.
//  6. R low for 1 cycle mid-LOAD -> all outputs 0 immediately. start during LOAD and during SWEEP -> no effect on the result.

Source files
------------

// File: rtl/key_unlock_pkg.sv
// Shared constants for the key-unlock sequencer: FSM state codes and default widths.
package key_unlock_pkg;
   localparam int KEY_W_DEF = 6;
   localparam int IN_W_DEF  = 5;
   localparam int OUT_W_DEF = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SWEEP = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/key_shift_reg.sv
// Serial-in/parallel-out key register, MSB shifted in first, with sync clear.
module key_shift_reg
   import key_unlock_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             C,
   input  logic             R,
   input  logic             clr_i,
   input  logic             shift_en_i,
   input  logic             sdi_i,
   output logic [KEY_W-1:0] key_o
);

   logic [KEY_W-1:0] key_q;

   // Clear wins over shift so a zeroise request can never be overwritten by a late beat.
   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         key_q <= '0;
      end else if (clr_i) begin
         key_q <= '0;
      end else if (shift_en_i) begin
         key_q <= {key_q[KEY_W-2:0], sdi_i};
      end
   end

   assign key_o = key_q;

endmodule

// File: rtl/key_unlock_seq.sv
// Loads a locking key serially, sweeps every primary-input pattern through the
// locked/golden pair, counts non-equal patterns and reports pass/fail.
module key_unlock_seq
   import key_unlock_pkg::*;
#(
   parameter int   KEY_W         = KEY_W_DEF,
   parameter int   IN_W          = IN_W_DEF,
   parameter int   OUT_W         = OUT_W_DEF,
   parameter logic CLEAR_ON_FAIL = 1'b1
) (
   input  logic             C,
   input  logic             R,
   input  logic             start,
   input  logic             abort,
   input  logic             key_sdi,
   input  logic             key_sdi_vld,
   input  logic [OUT_W-1:0] eq,
   output logic [IN_W-1:0]  pi,
   output logic [KEY_W-1:0] key_q,
   output logic             key_ok,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [IN_W:0]    mismatch_cnt
);

   localparam int              CNT_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(KEY_W - 1);
   localparam logic [IN_W-1:0]  PI_LAST  = '1;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [IN_W-1:0]  pi_q, pi_d;
   logic [IN_W:0]    cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic             key_ok_q, key_ok_d;
   logic             key_clr, key_shift;

   key_shift_reg #(.KEY_W(KEY_W)) u_key (
      .C         (C),
      .R         (R),
      .clr_i     (key_clr),
      .shift_en_i(key_shift),
      .sdi_i     (key_sdi),
      .key_o     (key_q)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      pi_d      = pi_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      key_ok_d  = key_ok_q;
      key_clr   = 1'b0;
      key_shift = 1'b0;
      if (abort) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         pi_d      = '0;
         cnt_d     = '0;
         pass_d    = 1'b0;
         key_ok_d  = 1'b0;
         key_clr   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d   = ST_LOAD;
                  bit_cnt_d = '0;
                  cnt_d     = '0;
                  pass_d    = 1'b0;
                  key_ok_d  = 1'b0;
                  key_clr   = 1'b1;
               end
            end
            ST_LOAD: begin
               if (key_sdi_vld) begin
                  key_shift = 1'b1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = ST_SWEEP;
                     pi_d    = '0;
                  end
               end
            end
            ST_SWEEP: begin
               if (!(&eq)) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // pi wraps to 0 on the last pattern, leaving it parked outside the sweep.
               pi_d = pi_q + 1'b1;
               if (pi_q == PI_LAST) begin
                  state_d = ST_DONE;
                  pass_d  = (cnt_d == '0);
               end
            end
            ST_DONE: begin
               state_d  = ST_IDLE;
               key_ok_d = pass_q;
               if (!pass_q && CLEAR_ON_FAIL) begin
                  key_clr = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         pi_q      <= '0;
         cnt_q     <= '0;
         pass_q    <= 1'b0;
         key_ok_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         pi_q      <= pi_d;
         cnt_q     <= cnt_d;
         pass_q    <= pass_d;
         key_ok_q  <= key_ok_d;
      end
   end

   assign pi           = pi_q;
   assign mismatch_cnt = cnt_q;
   assign pass         = pass_q;
   assign key_ok       = key_ok_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_key_unlock_seq.sv
// Bench: key_unlock_seq driving a key-locked c17 and its golden copy through an eq wrapper.
module tb_key_unlock_seq;

   logic       C = 1'b0;
   logic       R = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       key_sdi = 1'b0;
   logic       key_sdi_vld = 1'b0;
   logic [1:0] eq;
   logic [4:0] pi;
   logic [5:0] key_q;
   logic       key_ok, busy, done, pass;
   logic [5:0] mismatch_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model window for the per-cycle compare process
   bit         m_on  = 1'b0;
   int         m_ss  = 0;
   int         m_end = 0;
   logic [5:0] m_key = '0;
   int         m_total = 0;

   always #5 C = ~C;
   always @(posedge C) cyc <= cyc + 1;

   // Golden c17: outputs {N23, N22}
   function automatic logic [1:0] gold_out(input logic [4:0] p);
      logic n10, n11, n16, n19, n22, n23;
      n10 = ~(p[4] & p[2]);
      n11 = ~(p[2] & p[1]);
      n16 = ~(p[3] & n11);
      n19 = ~(n11 & p[0]);
      n22 = ~(n10 & n16);
      n23 = ~(n16 & n19);
      return {n23, n22};
   endfunction

   // Locked c17; correct keys are 001010 and 111010 (k4/k5 cancel)
   function automatic logic [1:0] lock_out(input logic [4:0] p, input logic [5:0] k);
      logic n10, n11, n16, n19, n22, n23;
      n10 = ~(p[4] & p[2]) ^ k[0];
      n11 = ~(~(p[2] & p[1]) ^ k[3]);
      n16 = ~(p[3] & n11);
      n19 = ~(n11 & p[0]) ^ k[4] ^ k[5];
      n22 = ~(n10 & n16) ^ k[2];
      n23 = ~(~(n16 & n19) ^ k[1]);
      return {n23, n22};
   endfunction

   function automatic int mm_prefix(input logic [5:0] k, input int n);
      int c = 0;
      for (int p = 0; p < n; p++) begin
         if (lock_out(5'(p), k) != gold_out(5'(p))) c++;
      end
      return c;
   endfunction

   assign eq = ~(lock_out(pi, key_q) ^ gold_out(pi));

   key_unlock_seq #(
      .KEY_W(6), .IN_W(5), .OUT_W(2), .CLEAR_ON_FAIL(1'b1)
   ) dut (
      .C(C), .R(R), .start(start), .abort(abort),
      .key_sdi(key_sdi), .key_sdi_vld(key_sdi_vld), .eq(eq),
      .pi(pi), .key_q(key_q), .key_ok(key_ok), .busy(busy),
      .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_loop();
      int idx;
      forever begin
         @(negedge C);
         if (m_on && cyc >= m_ss && cyc <= m_end) begin
            idx = cyc - m_ss;
            chk("busy_in_run", int'(busy), 1);
            chk("key_in_run", int'(key_q), int'(m_key));
            if (idx < 32) begin
               chk("sweep_pi", int'(pi), idx);
               chk("sweep_cnt", int'(mismatch_cnt), mm_prefix(m_key, idx));
               chk("sweep_done", int'(done), 0);
               chk("sweep_pass", int'(pass), 0);
            end else begin
               chk("model_done", int'(done), 1);
               chk("model_cnt", int'(mismatch_cnt), m_total);
               chk("model_pass", int'(pass), (m_total == 0) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_pi"}, int'(pi), 0);
      chk({tag, "_key_q"}, int'(key_q), 0);
      chk({tag, "_cnt"}, int'(mismatch_cnt), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_key_ok"}, int'(key_ok), 0);
   endtask

   // One full transaction; abort_at >= 0 aborts the sweep when pi reaches that value.
   task automatic run(input logic [5:0] key, input bit stall, input bit noise,
                      input int abort_at, input int exp_lat, input int exp_cnt, input bit exp_pass);
      int  c0, waited;
      bit  seen;
      @(posedge C); #1;
      start   = 1'b1;
      c0      = cyc;
      m_key   = key;
      m_ss    = c0 + 1 + (stall ? 11 : 6);
      m_end   = (abort_at >= 0) ? m_ss + abort_at : m_ss + 32;
      m_total = mm_prefix(key, 32);
      m_on    = 1'b1;
      @(posedge C); #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         key_sdi     = key[5-i];
         key_sdi_vld = 1'b1;
         start       = noise && (i == 2);
         @(posedge C); #1;
         if (stall && i < 5) begin
            key_sdi_vld = 1'b0;
            key_sdi     = ~key[5-i];
            start       = 1'b0;
            @(posedge C); #1;
         end
      end
      key_sdi_vld = 1'b0;
      start       = 1'b0;
      if (abort_at >= 0) begin
         repeat (abort_at) @(posedge C);
         #1;
         chk("abort_pi", int'(pi), abort_at);
         abort = 1'b1;
         @(posedge C); #1;
         abort = 1'b0;
         m_on  = 1'b0;
         check_all_zero("abort");
         seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(posedge C); #1;
            if (done) seen = 1'b1;
         end
         chk("abort_no_done", int'(seen), 0);
         $display("txn abort key=%b at_pi=%0d busy=%0d key_q=%b", key, abort_at, busy, key_q);
      end else begin
         waited = 0;
         while (!done && waited < 100) begin
            if (noise) begin
               start       = (waited % 3 == 0);
               key_sdi_vld = 1'b1;
               key_sdi     = waited[0];
            end
            @(posedge C); #1;
            waited++;
         end
         start       = 1'b0;
         key_sdi_vld = 1'b0;
         chk("done_seen", int'(done), 1);
         chk("latency", cyc - c0, exp_lat);
         chk("done_pass", int'(pass), int'(exp_pass));
         chk("done_cnt", int'(mismatch_cnt), exp_cnt);
         chk("done_key", int'(key_q), int'(key));
         @(posedge C); #1;
         m_on = 1'b0;
         chk("post_done", int'(done), 0);
         chk("post_busy", int'(busy), 0);
         chk("post_pass", int'(pass), int'(exp_pass));
         chk("post_key_ok", int'(key_ok), int'(exp_pass));
         chk("post_key_q", int'(key_q), exp_pass ? int'(key) : 0);
         chk("post_cnt", int'(mismatch_cnt), exp_cnt);
         chk("post_pi", int'(pi), 0);
         $display("txn key=%b stall=%0d noise=%0d latency=%0d cnt=%0d pass=%0d key_ok=%0d key_q=%b",
                  key, stall, noise, exp_lat, mismatch_cnt, pass, key_ok, key_q);
      end
   endtask

   initial begin
      fork
         compare_loop();
      join_none
      #3;
      check_all_zero("reset");
      @(posedge C); @(posedge C); #1;
      R = 1'b1;

      run(6'b001010, 1'b0, 1'b0, -1, 39, 0, 1'b1);
      run(6'b111010, 1'b0, 1'b0, -1, 39, 0, 1'b1);

      // key_sdi_vld while idle must not disturb the held key
      key_sdi = 1'b0; key_sdi_vld = 1'b1;
      repeat (2) @(posedge C);
      #1;
      key_sdi_vld = 1'b0;
      chk("idle_vld_ignored", int'(key_q), 6'b111010);
      $display("txn idle_vld key_q=%b", key_q);

      // start and abort together in IDLE: abort wins
      start = 1'b1; abort = 1'b1;
      @(posedge C); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", int'(busy), 0);
      chk("start_abort_key_ok", int'(key_ok), 0);
      chk("start_abort_key_q", int'(key_q), 0);
      $display("txn start+abort busy=%0d key_ok=%0d", busy, key_ok);

      run(6'b001110, 1'b0, 1'b0, -1, 39, 32, 1'b0);
      run(6'b001010, 1'b1, 1'b0, -1, 44, 0, 1'b1);
      run(6'b001010, 1'b0, 1'b0, 10, 0, 0, 1'b0);
      run(6'b001010, 1'b0, 1'b0, -1, 39, 0, 1'b1);

      // Async reset in the middle of LOAD
      @(posedge C); #1;
      start = 1'b1;
      @(posedge C); #1;
      start = 1'b0;
      key_sdi_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         key_sdi = 1'b1;
         @(posedge C); #1;
      end
      chk("preres_busy", int'(busy), 1);
      R = 1'b0;
      #1;
      check_all_zero("async_reset");
      key_sdi_vld = 1'b0;
      @(posedge C); #1;
      R = 1'b1;
      $display("txn async_reset busy=%0d key_q=%b", busy, key_q);

      run(6'b001010, 1'b0, 1'b1, -1, 39, 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
